// File: rtl/layer_load_sched.sv
// layer_load_sched: sequences per-layer weight loads from flash into the LeNet-5 NPU.
// One flash read per layer, beats forwarded with layer/beat tags, then hand-off to the NPU.
module layer_load_sched #(
    parameter int unsigned MAX_LAYERS = 8,
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_idx,
    input  logic [15:0]  cfg_beats,
    input  logic [3:0]   cfg_num_layers,
    input  logic         net_start,
    input  logic         abort,
    output logic         fr_start,
    output logic [23:0]  fr_start_addr,
    output logic [23:0]  fr_byte_num,
    input  logic         load_en,
    input  logic [255:0] load_data,
    output logic         w_en,
    output logic [255:0] w_data,
    output logic [2:0]   w_layer,
    output logic [15:0]  w_beat,
    output logic         layer_ready,
    input  logic         npu_layer_done,
    output logic         net_done,
    output logic         busy,
    output logic         err
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      MAX_N   = 4'(MAX_LAYERS);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_LOAD, S_WAIT_NPU, S_DONE, S_ERROR
    } state_t;

    state_t          state;
    logic [15:0]     tbl [MAX_LAYERS];
    logic [3:0]      n_layers;
    logic [2:0]      idx;
    logic [23:0]     acc;
    logic [15:0]     beat_cnt;
    logic [WD_W-1:0] wd;
    logic            ready_sent;

    logic [15:0]     cur_beats;
    logic            last_layer;

    assign cur_beats  = tbl[idx];
    assign last_layer = ({1'b0, idx} == (n_layers - 4'd1));

    // Beat data is a straight wire; only the tags are registered alongside w_en.
    assign w_data = load_data;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= S_IDLE;
            for (int i = 0; i < int'(MAX_LAYERS); i++) tbl[i] <= '0;
            n_layers      <= '0;
            idx           <= '0;
            acc           <= BASE_ADDR;
            beat_cnt      <= '0;
            wd            <= '0;
            ready_sent    <= 1'b0;
            fr_start      <= 1'b0;
            fr_start_addr <= '0;
            fr_byte_num   <= '0;
            w_en          <= 1'b0;
            w_layer       <= '0;
            w_beat        <= '0;
            layer_ready   <= 1'b0;
            net_done      <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            fr_start    <= 1'b0;
            layer_ready <= 1'b0;
            net_done    <= 1'b0;
            w_en        <= load_en && (state == S_LOAD);
            if (load_en && (state == S_LOAD)) begin
                w_layer <= idx;
                w_beat  <= beat_cnt;
            end

            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                err   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_ERROR: begin
                        if (cfg_we) tbl[cfg_idx] <= cfg_beats;
                        if (net_start) begin
                            n_layers <= (cfg_num_layers > MAX_N) ? MAX_N : cfg_num_layers;
                            idx      <= '0;
                            acc      <= BASE_ADDR;
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            state    <= (cfg_num_layers == 4'd0) ? S_DONE : S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        // Zero-beat layers are skipped without touching flash or the NPU.
                        if (cur_beats == 16'd0) begin
                            if (last_layer) state <= S_DONE;
                            else            idx   <= idx + 3'd1;
                        end else begin
                            fr_start      <= 1'b1;
                            fr_start_addr <= acc;
                            fr_byte_num   <= {3'b000, cur_beats, 5'b00000};
                            beat_cnt      <= '0;
                            wd            <= '0;
                            state         <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (load_en) begin
                            beat_cnt <= beat_cnt + 16'd1;
                            wd       <= '0;
                            if ((beat_cnt + 16'd1) == cur_beats) begin
                                ready_sent <= 1'b0;
                                state      <= S_WAIT_NPU;
                            end
                        end else if (wd == WD_LAST) begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            wd <= wd + WD_W'(1);
                        end
                    end
                    S_WAIT_NPU: begin
                        // First cycle raises layer_ready; done is honoured from that cycle on.
                        if (!ready_sent) begin
                            layer_ready <= 1'b1;
                            ready_sent  <= 1'b1;
                        end else if (npu_layer_done) begin
                            acc <= acc + {3'b000, cur_beats, 5'b00000};
                            if (last_layer) begin
                                state <= S_DONE;
                            end else begin
                                idx   <= idx + 3'd1;
                                state <= S_ISSUE;
                            end
                        end
                    end
                    S_DONE: begin
                        net_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_load_sched.sv
// tb_layer_load_sched: randomized pass/beat stimulus checked against a queue-based
// reference of expected flash commands, tagged beats and handshake timing.
module tb_layer_load_sched;

    localparam logic [23:0] BASE = 24'h000000;

    logic         sys_clk;
    logic         sys_rst_n;
    logic         cfg_we;
    logic [2:0]   cfg_idx;
    logic [15:0]  cfg_beats;
    logic [3:0]   cfg_num_layers;
    logic         net_start;
    logic         abort;
    logic         fr_start;
    logic [23:0]  fr_start_addr;
    logic [23:0]  fr_byte_num;
    logic         load_en;
    logic [255:0] load_data;
    logic         w_en;
    logic [255:0] w_data;
    logic [2:0]   w_layer;
    logic [15:0]  w_beat;
    logic         layer_ready;
    logic         npu_layer_done;
    logic         net_done;
    logic         busy;
    logic         err;

    layer_load_sched #(
        .MAX_LAYERS(8),
        .BASE_ADDR (BASE),
        .TIMEOUT   (16)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_beats     (cfg_beats),
        .cfg_num_layers(cfg_num_layers),
        .net_start     (net_start),
        .abort         (abort),
        .fr_start      (fr_start),
        .fr_start_addr (fr_start_addr),
        .fr_byte_num   (fr_byte_num),
        .load_en       (load_en),
        .load_data     (load_data),
        .w_en          (w_en),
        .w_data        (w_data),
        .w_layer       (w_layer),
        .w_beat        (w_beat),
        .layer_ready   (layer_ready),
        .npu_layer_done(npu_layer_done),
        .net_done      (net_done),
        .busy          (busy),
        .err           (err)
    );

    typedef struct {
        logic [23:0] addr;
        logic [23:0] bytes;
    } cmd_t;

    typedef struct {
        logic [2:0]   layer;
        logic [15:0]  beat;
        logic [255:0] data;
        int           due;
    } wexp_t;

    cmd_t  cq[$];
    wexp_t wq[$];
    int    shadow[8];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    ready_cnt = 0;
    int    done_cnt = 0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Expected flash commands for a pass: running byte sum over non-empty layers.
    function automatic void model_cmds(input int n);
        logic [23:0] a;
        cmd_t c;
        a = BASE;
        for (int i = 0; i < n; i++) begin
            if (shadow[i] != 0) begin
                c.addr  = a;
                c.bytes = 24'(shadow[i]) * 24'd32;
                cq.push_back(c);
                a = a + c.bytes;
            end
        end
    endfunction

    // Output monitor: commands and beats are consumed in order from the reference queues.
    always @(negedge sys_clk) begin : mon
        cmd_t  c;
        wexp_t e;
        bit    ew;
        if (sys_rst_n) begin
            if (fr_start) begin
                if (cq.size() == 0) begin
                    check("fr_start_unexpected", 256'(1), 256'(0));
                end else begin
                    c = cq.pop_front();
                    check("fr_addr", 256'(fr_start_addr), 256'(c.addr));
                    check("fr_bytes", 256'(fr_byte_num), 256'(c.bytes));
                end
            end
            ew = (wq.size() > 0) && (wq[0].due == cyc);
            if (w_en || ew) begin
                check("w_en", 256'(w_en), 256'(ew));
                if (w_en && ew) begin
                    e = wq.pop_front();
                    check("w_layer", 256'(w_layer), 256'(e.layer));
                    check("w_beat", 256'(w_beat), 256'(e.beat));
                    check("w_data", w_data, e.data);
                end
            end
            if (layer_ready) ready_cnt++;
            if (net_done) done_cnt++;
        end
    end

    task automatic write_tbl(input int i, input int b, input bit honoured);
        cfg_we = 1'b1; cfg_idx = 3'(i); cfg_beats = 16'(b);
        tick();
        cfg_we = 1'b0;
        if (honoured) shadow[i] = b;
    endtask

    task automatic drive_beats(input int layer, input int nb, input bit dense);
        int sent, idle;
        bit pend_v;
        logic [255:0] pend;
        wexp_t e;
        sent = 0; idle = 0; pend_v = 1'b0; pend = '0;
        while (sent < nb || pend_v) begin
            load_data = pend_v ? pend : rand256();
            pend_v = 1'b0;
            if (sent < nb && (dense || idle >= 3 || $urandom_range(0, 2) != 0)) begin
                pend    = rand256();
                pend_v  = 1'b1;
                e.layer = 3'(layer);
                e.beat  = 16'(sent);
                e.data  = pend;
                e.due   = cyc + 1;
                wq.push_back(e);
                load_en = 1'b1;
                sent++;
                idle = 0;
            end else begin
                load_en = 1'b0;
                idle++;
            end
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic wait_fr(input int bound, output int k);
        k = 0;
        while (!fr_start && k < bound) begin tick(); k++; end
        check("fr_seen", 256'(fr_start), 256'(1));
    endtask

    task automatic wait_nd(input int bound, output int k);
        k = 0;
        while (!net_done && k < bound) begin tick(); k++; end
        check("net_done_seen", 256'(net_done), 256'(1));
    endtask

    // One full pass; each skipped layer costs exactly one extra cycle before the next event.
    task automatic run_pass(input logic [3:0] num, input bit dense, input int max_dly);
        int n, k, skips, reals, r0, d0;
        n = (num > 4'd8) ? 8 : int'(num);
        model_cmds(n);
        r0 = ready_cnt; d0 = done_cnt; skips = 0; reals = 0;
        cfg_num_layers = num;
        net_start = 1'b1;
        tick();
        net_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (shadow[i] == 0) begin
                skips++;
                continue;
            end
            wait_fr(8 + skips, k);
            check("fr_latency", 256'(k), 256'(1 + skips));
            check("busy_load", 256'(busy), 256'(1));
            check("err_load", 256'(err), 256'(0));
            drive_beats(i, shadow[i], dense);
            check("layer_ready_t2", 256'(layer_ready), 256'(1));
            repeat ($urandom_range(0, max_dly)) tick();
            npu_layer_done = 1'b1;
            tick();
            npu_layer_done = 1'b0;
            skips = 0;
            reals++;
        end
        wait_nd(8 + skips, k);
        check("net_done_latency", 256'(k), 256'(1 + skips));
        check("busy_end", 256'(busy), 256'(0));
        tick();
        check("ready_count", 256'(ready_cnt - r0), 256'(reals));
        check("done_count", 256'(done_cnt - d0), 256'(1));
        check("cmd_left", 256'(cq.size()), 256'(0));
        check("beat_left", 256'(wq.size()), 256'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 256'({fr_start, fr_start_addr, fr_byte_num, w_en, w_layer, w_beat,
                         layer_ready, net_done, busy, err}), 256'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, r0, d0;
        sys_rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_beats = '0; cfg_num_layers = '0;
        net_start = 1'b0; abort = 1'b0; load_en = 1'b0; load_data = '0; npu_layer_done = 1'b0;
        for (int i = 0; i < 8; i++) shadow[i] = 0;
        repeat (3) tick();
        check_all_zero("reset_outputs");
        sys_rst_n = 1'b1;
        tick();
        check("idle_busy", 256'(busy), 256'(0));

        // Two real layers, then back-to-back beats with done already high.
        write_tbl(0, 4, 1'b1); write_tbl(1, 2, 1'b1);
        run_pass(4'd2, 1'b0, 2);
        write_tbl(0, 3, 1'b1); write_tbl(1, 5, 1'b1);
        run_pass(4'd2, 1'b1, 0);

        // Skipped middle layer.
        write_tbl(0, 3, 1'b1); write_tbl(1, 0, 1'b1); write_tbl(2, 1, 1'b1);
        run_pass(4'd3, 1'b0, 1);

        // Stall after one of four beats trips the watchdog after 16 idle cycles.
        write_tbl(0, 4, 1'b1);
        model_cmds(1);
        r0 = ready_cnt;
        cfg_num_layers = 4'd1; net_start = 1'b1; tick(); net_start = 1'b0;
        wait_fr(8, k);
        check("stall_fr_latency", 256'(k), 256'(1));
        drive_beats(0, 1, 1'b1);
        repeat (14) tick();
        check("stall_err_early", 256'({err, busy}), 256'(2'b01));
        tick();
        check("stall_err", 256'({err, busy}), 256'(2'b10));
        tick();
        check("stall_no_ready", 256'(ready_cnt - r0), 256'(0));
        check("stall_cmd_left", 256'(cq.size()), 256'(0));
        check("stall_beat_left", 256'(wq.size()), 256'(0));
        write_tbl(0, 4, 1'b1);
        run_pass(4'd1, 1'b0, 1);

        // Abort mid-LOAD; a write during the pass must not land.
        write_tbl(0, 4, 1'b1); write_tbl(1, 2, 1'b1);
        model_cmds(1);
        cfg_num_layers = 4'd2; net_start = 1'b1; tick(); net_start = 1'b0;
        wait_fr(8, k);
        drive_beats(0, 2, 1'b1);
        write_tbl(0, 9, 1'b0);
        r0 = ready_cnt; d0 = done_cnt;
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy", 256'({busy, err}), 256'(0));
        load_en = 1'b1; load_data = rand256();
        repeat (3) tick();
        load_en = 1'b0;
        repeat (3) tick();
        check("abort_no_ready", 256'(ready_cnt - r0), 256'(0));
        check("abort_no_done", 256'(done_cnt - d0), 256'(0));
        check("abort_cmd_left", 256'(cq.size()), 256'(0));
        run_pass(4'd2, 1'b0, 2);

        // net_start together with abort: nothing starts.
        d0 = done_cnt;
        net_start = 1'b1; abort = 1'b1; tick(); net_start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 256'(busy), 256'(0));
        repeat (4) tick();
        check("start_abort_no_done", 256'(done_cnt - d0), 256'(0));

        // Empty pass.
        run_pass(4'd0, 1'b0, 0);

        // Randomized passes, including layer counts above the table depth.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 8; i++)
                write_tbl(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 5)), 1'b1);
            run_pass(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3);
        end

        // Reset while waiting on the NPU clears outputs and the table.
        write_tbl(0, 2, 1'b1);
        model_cmds(1);
        cfg_num_layers = 4'd1; net_start = 1'b1; tick(); net_start = 1'b0;
        wait_fr(8, k);
        drive_beats(0, 2, 1'b1);
        check("pre_reset_ready", 256'(layer_ready), 256'(1));
        sys_rst_n = 1'b0;
        #2;
        check_all_zero("midpass_reset_outputs");
        tick(); tick();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) shadow[i] = 0;
        cq.delete();
        wq.delete();
        tick();
        run_pass(4'd1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
